// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl_if
// Brief    : Decode-side fields into, and EX-stage control out of, the
//            forwarding / hazard controller.
// Revision : 1.0  initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
);
    logic                  valid_d;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  use_rs1_d;
    logic                  use_rs2_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic                  regwrite_d;
    logic                  memread_d;
    logic                  pc_src_e;

    logic [1:0]            fwd_a_e;
    logic [1:0]            fwd_b_e;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic [PERF_W-1:0]     stall_cnt;
    logic [PERF_W-1:0]     flush_cnt;

    // Pipeline side: supplies decode fields and the EX branch decision
    modport master (
        output valid_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
               rd_d, regwrite_d, memread_d, pc_src_e,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
               stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  valid_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
               rd_d, regwrite_d, memread_d, pc_src_e,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
               stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Brief    : EX-stage operand forwarding selects, load-use stall and branch
//            flush generation, driven from a shadow copy of the EX/MEM/WB
//            register-write metadata.
// Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fwd_hazard_ctrl_if.slave   bus
);

    localparam logic [1:0]        c_SEL_RF  = 2'b00;
    localparam logic [1:0]        c_SEL_WB  = 2'b01;
    localparam logic [1:0]        c_SEL_MEM = 2'b10;
    localparam logic [PERF_W-1:0] c_CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] c_CNT_MAX = {PERF_W{1'b1}};

    // Shadow stage metadata
    logic                  r_e_v, r_e_rw, r_e_mr;
    logic [REG_ADDR_W-1:0] r_e_rd;
    logic                  r_m_v, r_m_rw;
    logic [REG_ADDR_W-1:0] r_m_rd;
    logic                  r_w_v, r_w_rw;
    logic [REG_ADDR_W-1:0] r_w_rd;

    logic [1:0]            r_fwd_a, r_fwd_b;
    logic [PERF_W-1:0]     r_stall_cnt, r_flush_cnt;

    logic                  w_lu;
    logic                  w_branch;
    logic                  w_stall_f, w_stall_d, w_flush_d, w_flush_e;
    logic                  w_advance;
    logic [1:0]            w_sel_a, w_sel_b;

    // Load-use detect and branch/stall priority; everything held low in reset
    always_comb begin
        w_lu      = 1'b0;
        w_branch  = 1'b0;
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (rst_n) begin
            w_lu = bus.valid_d & r_e_v & r_e_mr & (r_e_rd != '0) &
                   ((bus.use_rs1_d & (bus.rs1_d == r_e_rd)) |
                    (bus.use_rs2_d & (bus.rs2_d == r_e_rd)));
            w_branch = bus.pc_src_e;
            if (w_branch) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_lu) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end
        end
    end

    // The decode instruction moves into EX only when EX is not being cleared
    assign w_advance = ~w_flush_e;

    // Select for each operand: newest producer first, x0 never forwards
    always_comb begin
        w_sel_a = c_SEL_RF;
        w_sel_b = c_SEL_RF;
        if (bus.use_rs1_d & r_e_v & r_e_rw & (r_e_rd != '0) & (r_e_rd == bus.rs1_d))
            w_sel_a = c_SEL_MEM;
        else if (bus.use_rs1_d & r_m_v & r_m_rw & (r_m_rd != '0) & (r_m_rd == bus.rs1_d))
            w_sel_a = c_SEL_WB;
        if (bus.use_rs2_d & r_e_v & r_e_rw & (r_e_rd != '0) & (r_e_rd == bus.rs2_d))
            w_sel_b = c_SEL_MEM;
        else if (bus.use_rs2_d & r_m_v & r_m_rw & (r_m_rd != '0) & (r_m_rd == bus.rs2_d))
            w_sel_b = c_SEL_WB;
    end

    // Shadow pipeline advance and registered forward selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_v   <= 1'b0;
            r_e_rw  <= 1'b0;
            r_e_mr  <= 1'b0;
            r_e_rd  <= '0;
            r_m_v   <= 1'b0;
            r_m_rw  <= 1'b0;
            r_m_rd  <= '0;
            r_w_v   <= 1'b0;
            r_w_rw  <= 1'b0;
            r_w_rd  <= '0;
            r_fwd_a <= c_SEL_RF;
            r_fwd_b <= c_SEL_RF;
        end else begin
            r_m_v  <= r_e_v;
            r_m_rw <= r_e_rw;
            r_m_rd <= r_e_rd;
            r_w_v  <= r_m_v;
            r_w_rw <= r_m_rw;
            r_w_rd <= r_m_rd;
            if (w_advance) begin
                r_e_v   <= bus.valid_d;
                r_e_rw  <= bus.regwrite_d;
                r_e_mr  <= bus.memread_d;
                r_e_rd  <= bus.rd_d;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end else begin
                // Bubble: keep the index, kill every qualifier
                r_e_v   <= 1'b0;
                r_e_rw  <= 1'b0;
                r_e_mr  <= 1'b0;
                r_fwd_a <= c_SEL_RF;
                r_fwd_b <= c_SEL_RF;
            end
        end
    end

    // Saturating stall / flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu && !w_branch && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_branch && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign bus.fwd_a_e   = r_fwd_a;
    assign bus.fwd_b_e   = r_fwd_b;
    assign bus.stall_f   = w_stall_f;
    assign bus.stall_d   = w_stall_d;
    assign bus.flush_d   = w_flush_d;
    assign bus.flush_e   = w_flush_e;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Brief    : Directed self-checking bench for fwd_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int PERF_W     = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .PERF_W(PERF_W)) u_if ();

    fwd_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .PERF_W(PERF_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Place an instruction in decode
    task automatic drive(input logic v, input int rs1, input int rs2, input logic u1,
                         input logic u2, input int rd, input logic rw, input logic mr);
        u_if.valid_d    = v;
        u_if.rs1_d      = rs1[REG_ADDR_W-1:0];
        u_if.rs2_d      = rs2[REG_ADDR_W-1:0];
        u_if.use_rs1_d  = u1;
        u_if.use_rs2_d  = u2;
        u_if.rd_d       = rd[REG_ADDR_W-1:0];
        u_if.regwrite_d = rw;
        u_if.memread_d  = mr;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control outputs packed {stall_f, stall_d, flush_d, flush_e}
    function automatic logic [31:0] ctl();
        return {28'd0, u_if.stall_f, u_if.stall_d, u_if.flush_d, u_if.flush_e};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        u_if.pc_src_e = 1'b0;
        nop();
        repeat (3) tick();
        check("rst_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd0);
        check("rst_fwd_b", {30'd0, u_if.fwd_b_e}, 32'd0);
        check("rst_ctl", ctl(), 32'd0);
        check("rst_cnts", {u_if.stall_cnt, u_if.flush_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // EX-EX: add x3,x1,x2 ; sub x4,x3,x1
        drive(1, 1, 2, 1, 1, 3, 1, 0); tick();
        drive(1, 3, 1, 1, 1, 4, 1, 0); #1;
        check("exex_nostall", ctl(), 32'd0);
        tick(); nop();
        check("exex_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd2);
        check("exex_fwd_b", {30'd0, u_if.fwd_b_e}, 32'd0);
        repeat (3) tick();

        // Newest wins: add x3 ; add x3 ; or x6,x3,x3
        drive(1, 1, 2, 1, 1, 3, 1, 0); tick();
        drive(1, 2, 1, 1, 1, 3, 1, 0); tick();
        drive(1, 3, 3, 1, 1, 6, 1, 0); tick(); nop();
        check("newest_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd2);
        check("newest_fwd_b", {30'd0, u_if.fwd_b_e}, 32'd2);
        repeat (3) tick();

        // MEM-EX: add x3 ; nop ; or x6,x3,x3
        drive(1, 1, 2, 1, 1, 3, 1, 0); tick();
        nop(); tick();
        drive(1, 3, 3, 1, 1, 6, 1, 0); tick(); nop();
        check("memex_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd1);
        check("memex_fwd_b", {30'd0, u_if.fwd_b_e}, 32'd1);
        repeat (3) tick();

        // Load-use: lw x7,0(x1) ; add x8,x7,x2
        drive(1, 1, 0, 1, 0, 7, 1, 1); tick();
        drive(1, 7, 2, 1, 1, 8, 1, 0); #1;
        check("lu_ctl", ctl(), 32'b1101);
        tick();
        check("lu_cnt", {16'd0, u_if.stall_cnt}, 32'd1);
        check("lu_bubble_fwd", {28'd0, u_if.fwd_a_e, u_if.fwd_b_e}, 32'd0);
        check("lu_released", ctl(), 32'd0);
        tick(); nop();
        check("lu_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd1);
        check("lu_fwd_b", {30'd0, u_if.fwd_b_e}, 32'd0);
        check("lu_cnt_hold", {16'd0, u_if.stall_cnt}, 32'd1);
        repeat (3) tick();

        // x0 destination never stalls or forwards
        drive(1, 1, 0, 1, 0, 0, 1, 1); tick();
        drive(1, 0, 0, 1, 1, 1, 1, 0); #1;
        check("x0_nostall", ctl(), 32'd0);
        tick(); nop();
        check("x0_fwd", {28'd0, u_if.fwd_a_e, u_if.fwd_b_e}, 32'd0);
        repeat (3) tick();

        // Unused sources: lw x9 ; lui x9
        drive(1, 1, 0, 1, 0, 9, 1, 1); tick();
        drive(1, 9, 9, 0, 0, 9, 1, 0); #1;
        check("lui_nostall", ctl(), 32'd0);
        tick(); nop();
        repeat (3) tick();

        // Branch beats load-use in the same cycle
        drive(1, 1, 0, 1, 0, 7, 1, 1); tick();
        drive(1, 7, 2, 1, 1, 8, 1, 0);
        u_if.pc_src_e = 1'b1; #1;
        check("br_ctl", ctl(), 32'b0011);
        tick();
        u_if.pc_src_e = 1'b0; nop();
        check("br_flush_cnt", {16'd0, u_if.flush_cnt}, 32'd1);
        check("br_stall_cnt", {16'd0, u_if.stall_cnt}, 32'd1);
        repeat (3) tick();

        // Async reset with a load to x5 sitting in EX
        drive(1, 1, 0, 1, 0, 5, 1, 1); tick();
        drive(1, 5, 0, 1, 0, 6, 1, 0); #1;
        check("prerst_stall", ctl(), 32'b1101);
        rst_n = 1'b0; #1;
        check("arst_ctl", ctl(), 32'd0);
        check("arst_cnts", {u_if.stall_cnt, u_if.flush_cnt}, 32'd0);
        rst_n = 1'b1; #1;
        check("post_rst_nostall", ctl(), 32'd0);
        tick(); nop();
        check("post_rst_fwd_a", {30'd0, u_if.fwd_a_e}, 32'd0);
        repeat (2) tick();

        // Flush counter saturation
        u_if.pc_src_e = 1'b1;
        repeat ((1 << PERF_W) + 3) tick();
        u_if.pc_src_e = 1'b0;
        check("flush_sat", {16'd0, u_if.flush_cnt}, 32'h0000_FFFF);
        check("sat_stall_cnt", {16'd0, u_if.stall_cnt}, 32'd0);
        tick();
        check("flush_sat_hold", {16'd0, u_if.flush_cnt}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
